rv_dmem_responder: RTL and testbench

- Memory-side responder for the RVCPU data bus: accepts load/store requests issued by the CPU core, inserts a configurable number of wait states, then returns a response.
- Holds a word-organised RAM and performs byte/half/word lane steering plus load sign/zero extension.
- Flags misaligned and out-of-range accesses.
- Used as the data memory in the RVCPU top level and as a standalone bus model in CPU benches.

---
 rtl/rv_dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_rv_dmem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_dmem_responder.sv
// Data-memory responder for the RVCPU bus: single outstanding request, configurable
// wait states, byte/half/word lane steering with load extension and access checking.
module rv_dmem_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   word_idx;
    logic               align_err;
    logic               range_err;
    logic               access_err;
    logic [31:0]        rd_word;
    logic [31:0]        shifted;
    logic [31:0]        load_data;
    logic [31:0]        wr_data;
    logic [3:0]         wr_be;
    logic               commit;

    assign word_idx   = addr_q[IDX_W+1:2];
    assign range_err  = (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign access_err = align_err | range_err;
    assign rd_word    = mem[word_idx];
    assign shifted    = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        align_err = 1'b0;
        load_data = rd_word;
        wr_data   = wdata_q;
        wr_be     = 4'b1111;
        case (size_q)
            2'b00: begin
                load_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                wr_data   = {4{wdata_q[7:0]}};
                wr_be     = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                align_err = addr_q[0];
                load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                wr_data   = {2{wdata_q[15:0]}};
                wr_be     = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                align_err = |addr_q[1:0];
            end
            default: begin
                align_err = 1'b1;
            end
        endcase
    end

    // The counter loads WAIT_CYCLES after acceptance so the response appears
    // WAIT_CYCLES+1 edges after the accepting edge, including the zero-wait case.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        commit      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = rst;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    commit      = 1'b1;
                    rsp_err_d   = access_err;
                    rsp_rdata_d = (we_q || access_err) ? 32'h0 : load_data;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM is deliberately left out of reset; a store pending during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && commit && we_q && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// Directed bench for rv_dmem_responder: one DUT with two wait states and one with none,
// sharing request inputs; sel chooses which DUT sees req_valid and whose outputs are observed.
module tb_rv_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        sel;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    int checks;
    int failures;

    rv_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    rv_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut_zw (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(z_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    assign req_ready_m = sel ? z_req_ready : a_req_ready;
    assign rsp_valid_m = sel ? z_rsp_valid : a_rsp_valid;
    assign rsp_rdata_m = sel ? z_rsp_rdata : a_rsp_rdata;
    assign rsp_err_m   = sel ? z_rsp_err   : a_rsp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from just after an edge; lat counts edges after the accepting
    // edge until rsp_valid is seen (-1 if never). Completes the handshake if rsp_ready=1.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; rdata = 32'h0; err = 1'b0;
        if (rsp_valid_m) lat = 0;
        for (int n = 1; n <= 16 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (rsp_valid_m) lat = n;
        end
        if (lat >= 0) begin
            rdata = rsp_rdata_m;
            err   = rsp_err_m;
            if (rsp_ready) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; sel = 1'b0;
        req_we = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (req_ready_m !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready_m); end
        checks++; if (rsp_valid_m !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_m); end
        checks++; if (rsp_rdata_m !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata_m); end
        checks++; if (rsp_err_m !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err_m); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready_m !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready_m); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, er);
        checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", rd); end
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er);
        checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_word got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL load_word_err got=%b exp=0", er); end
    endtask

    task automatic test_load_ext();
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, addrs[i], sizes[i], unss[i], 32'h0, lat, rd, er);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL load_ext[%0d] got=%h err=%b exp=%h err=0", i, rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h12345655, lat, rd, er);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL byte_store_err got=%b exp=0", er); end
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL byte_store_merge got=%h exp=dead55ef", rd); end
    endtask

    task automatic test_errors();
        logic        wes   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] addrs [4] = '{32'h12, 32'h11, 32'h1000, 32'h10};
        logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        logic [31:0] wds   [4] = '{32'h0, 32'h0000FFFF, 32'h11111111, 32'h77777777};
        logic [31:0] chk_a [4] = '{32'h10, 32'h10, 32'h0, 32'h10};
        logic [31:0] chk_e [4] = '{32'hDEAD55EF, 32'hDEAD55EF, 32'h0, 32'hDEAD55EF};
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h0, lat, rd, er);
        for (int i = 0; i < 4; i++) begin
            do_req(wes[i], addrs[i], sizes[i], 1'b0, wds[i], lat, rd, er);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
                failures++;
                $display("FAIL err_case[%0d] got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=3", i, er, rd, lat);
            end
            do_req(1'b0, chk_a[i], 2'b10, 1'b0, 32'h0, lat, rd, er);
            checks++;
            if (rd !== chk_e[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL err_mem_unchanged[%0d] got=%h err=%b exp=%h err=0", i, rd, er, chk_e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er;
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er);
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid_m !== 1'b1 || rsp_rdata_m !== 32'hDEAD55EF || rsp_err_m !== 1'b0 || req_ready_m !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got valid=%b rdata=%h err=%b req_ready=%b exp 1 dead55ef 0 0",
                         c, rsp_valid_m, rsp_rdata_m, rsp_err_m, req_ready_m);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got req_ready=%b rsp_valid=%b exp 1 0", req_ready_m, rsp_valid_m);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, lat, rd, er);
        checks++; if (req_ready_m !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready_m); end
        do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, lat, rd, er);
        checks++;
        if (lat !== 3 || rd !== 32'h00000055) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d rdata=%h exp lat=3 rdata=00000055", lat, rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [31:0] rd; logic er; int seen;
        do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, er);
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready_m !== 1'b0) begin failures++; $display("FAIL wait_req_ready got=%b exp=0", req_ready_m); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid_m) seen = 1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_wait_rsp_valid got=%0d exp=0", seen); end
        checks++; if (req_ready_m !== 1'b1) begin failures++; $display("FAIL mid_wait_idle got=%b exp=1", req_ready_m); end
        do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_wait_discard got=%h exp=0", rd); end
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] rd; logic er;
        sel = 1'b1;
        #1;
        do_req(1'b1, 32'h8, 2'b10, 1'b0, 32'h0BADF00D, lat, rd, er);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zw_store_latency got=%0d exp=1", lat); end
        do_req(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, lat, rd, er);
        checks++;
        if (lat !== 1 || rd !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL zw_load got lat=%0d rdata=%h exp lat=1 rdata=0badf00d", lat, rd);
        end
        do_req(1'b0, 32'hA, 2'b01, 1'b0, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h00000BAD) begin failures++; $display("FAIL zw_half got=%h exp=00000bad", rd); end
        sel = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_store_load();
        test_load_ext();
        test_byte_store();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
